// File: rtl/mips32_boot_pkg.sv
// Shared constants and FSM encoding for the byte-serial boot loader.
package mips32_boot_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned CNT_W          = 16;

    localparam logic [BYTE_W-1:0] CMD_LOAD_I  = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_LOAD_D  = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_CLR_ERR = 8'h0C;
    localparam logic [BYTE_W-1:0] CMD_HALT    = 8'h0E;
    localparam logic [BYTE_W-1:0] CMD_RUN     = 8'h0F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_HI,
        S_A_LO,
        S_C_HI,
        S_C_LO,
        S_DATA,
        S_WR,
        S_CSUM,
        S_RUN
    } boot_state_e;

endpackage

// File: rtl/mips32_boot_loader_asm.sv
// Packs four big-endian bytes into one memory word; word_valid_c flags the 4th byte.
module boot_word_assembler
    import mips32_boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_c
);

    localparam int unsigned BCNT_W = $clog2(BYTES_PER_WORD);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Shift in one byte per accepted beat; clear discards any partial word.
    always_comb begin
        bcnt_d = bcnt_q;
        word_d = word_q;
        if (clr_i) begin
            bcnt_d = '0;
            word_d = '0;
        end else if (byte_valid_i) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
        end
    end

    // Byte counter and word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            word_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_c = byte_valid_i && !clr_i && (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips32_boot_loader.sv
// Byte-serial boot loader: parses host frames, writes imem/dmem words, gates the core.
// Optional trailing frame checksum is enabled with the BOOT_CHECKSUM_EN macro.
module mips32_boot_loader
    import mips32_boot_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              err
);

    boot_state_e       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              load_done_q, load_done_d;
    logic              err_q, err_d;
    logic [BYTE_W-1:0] addr_hi_q, addr_hi_d;
    logic [BYTE_W-1:0] cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;
`endif

    logic              byte_acc;
    logic              frame_done;
    logic              asm_clr;
    logic              asm_byte_v;
    logic [WORD_W-1:0] asm_word;
    logic              asm_word_valid;

    assign byte_acc = in_valid && in_ready_q;

    boot_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (asm_clr),
        .byte_valid_i (asm_byte_v),
        .byte_i       (in_data),
        .word_o       (asm_word),
        .word_valid_c (asm_word_valid)
    );

    // Frame parser, write handshake and command decode; outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        wr_sel_d     = wr_sel_q;
        wr_addr_d    = wr_addr_q;
        load_done_d  = 1'b0;
        err_d        = err_q;
        addr_hi_d    = addr_hi_q;
        cnt_hi_d     = cnt_hi_q;
        words_left_d = words_left_q;
        frame_done   = 1'b0;
        asm_clr      = 1'b0;
        asm_byte_v   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_d        = sum_q;
        if (byte_acc && (state_q inside {S_A_HI, S_A_LO, S_C_HI, S_C_LO, S_DATA})) begin
            sum_d = sum_q + in_data;
        end
`endif

        case (state_q)
            S_IDLE, S_RUN: begin
                if (byte_acc) begin
                    case (in_data)
                        CMD_LOAD_I, CMD_LOAD_D: begin
                            if (state_q == S_IDLE) begin
                                state_d  = S_A_HI;
                                wr_sel_d = (in_data == CMD_LOAD_D);
                                asm_clr  = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                                sum_d    = '0;
`endif
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_RUN:     state_d = S_RUN;
                        CMD_HALT:    state_d = S_IDLE;
                        CMD_CLR_ERR: err_d   = 1'b0;
                        default:     err_d   = 1'b1;
                    endcase
                end
            end
            S_A_HI: if (byte_acc) begin
                addr_hi_d = in_data;
                state_d   = S_A_LO;
            end
            S_A_LO: if (byte_acc) begin
                wr_addr_d = ADDR_W'({addr_hi_q, in_data});
                state_d   = S_C_HI;
            end
            S_C_HI: if (byte_acc) begin
                cnt_hi_d = in_data;
                state_d  = S_C_LO;
            end
            S_C_LO: if (byte_acc) begin
                words_left_d = {cnt_hi_q, in_data};
                if ({cnt_hi_q, in_data} == CNT_W'(0)) frame_done = 1'b1;
                else                                  state_d    = S_DATA;
            end
            S_DATA: begin
                asm_byte_v = byte_acc;
                if (asm_word_valid) state_d = S_WR;
            end
            S_WR: if (wr_ready) begin
                wr_addr_d    = wr_addr_q + ADDR_W'(1);
                words_left_d = words_left_q - CNT_W'(1);
                if (words_left_q == CNT_W'(1)) frame_done = 1'b1;
                else                           state_d    = S_DATA;
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: if (byte_acc) begin
                state_d = S_IDLE;
                if (BYTE_W'(sum_q + in_data) == BYTE_W'(0)) load_done_d = 1'b1;
                else                                         err_d       = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (frame_done) begin
`ifdef BOOT_CHECKSUM_EN
            state_d     = S_CSUM;
`else
            state_d     = S_IDLE;
            load_done_d = 1'b1;
`endif
        end

        in_ready_d = (state_d != S_WR);
        wr_en_d    = (state_d == S_WR);
        busy_d     = !(state_d inside {S_IDLE, S_RUN});
        cpu_hold_d = (state_d != S_RUN);
    end

    // State and registered outputs; reset drops any partial frame or pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= 1'b0;
            wr_addr_q    <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
            addr_hi_q    <= '0;
            cnt_hi_q     <= '0;
            words_left_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_addr_q    <= wr_addr_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
            err_q        <= err_d;
            addr_hi_q    <= addr_hi_d;
            cnt_hi_q     <= cnt_hi_d;
            words_left_q <= words_left_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_sel    = wr_sel_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = DATA_W'(asm_word);
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign err       = err_q;

endmodule
